writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Captures the memory-stage outputs in the WB pipeline register and selects the register-file write value.
- Drives the regfile and CSR write ports, and produces a single-pulse retire indication.
- Maintains the 64-bit minstret/minstreth retired-instruction counter, including the CSR write override.

Parameters:
- CSR_MINSTRET_ADDR, 12'hB02, CSR address that writes counter bits [31:0].
- CSR_MINSTRETH_ADDR, 12'hB82, CSR address that writes counter bits [63:32].

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- instr_mem_i  in  32  instruction word from memory stage
- reduced_data_mem_i  in  32  width-reduced load data
- alu_result_mem_i / pc_target_mem_i / pc_plus4_mem_i / imm_ext_mem_i  in  32 each  result candidates
- csr_data_mem_i  in  32  old CSR value (rd result)
- csr_result_mem_i  in  32  new CSR value to write
- csr_addr_mem_i  in  12  CSR address
- rd_mem_i  in  5  destination register
- valid_mem_i, reg_write_mem_i, csr_we_mem_i  in  1 each  control
- result_src_mem_i  in  3  result select (control_macros encodings)
- stall_wb_i  in  1  hold WB register
- flush_wb_i  in  1  load bubble into WB register
- result_wb_o  out  32  regfile write data (also forwarding source)
- rd_wb_o  out  5  regfile write address
- reg_write_wb_o  out  1  regfile write enable
- csr_we_wb_o  out  1  CSR write enable (single pulse)
- csr_addr_wb_o  out  12  CSR write address
- csr_wdata_wb_o  out  32  CSR write data
- instr_wb_o  out  32  instruction in WB (trace)
- valid_wb_o  out  1  WB holds a valid instruction
- retire_o  out  1  one-cycle pulse per retired instruction
- instret_o  out  64  retired-instruction count

Behaviour:
- WB register priority, per clock: reset_i > flush_wb_i > stall_wb_i > load.
  - Reset and flush: every field 0, so valid=0, reg_write=0, csr_we=0.
  - Stall: hold current contents.
- Reset values: all outputs 0, instret_o = 0, retired flag = 0.
- Result mux (combinational from the registered fields):
  - RESULT_ALU -> alu_result
  - RESULT_MEM -> reduced_data
  - RESULT_PCTARGET -> pc_target
  - RESULT_PCPLUS4 -> pc_plus4
  - RESULT_IMM_EXT -> imm_ext
  - RESULT_CSR -> csr_data
  - any other encoding -> 32'h0
- reg_write_wb_o = reg_write_q & valid_q & (rd_q != 0). The write may repeat during a stall; this is idempotent.
- Retired flag:
  - first_q = valid_q & ~retired_flag.
  - retired_flag sets when first_q & stall_wb_i.
  - retired_flag clears whenever the register loads, flushes or resets.
- retire_o = first_q: exactly one pulse per instruction, regardless of stall length.
- csr_we_wb_o = csr_we_q & first_q: exactly one pulse per instruction, never repeated during a stall.
- Latency: inputs appear on outputs one cycle after a non-stalled, non-flushed edge.
- Counter update each cycle, with csr_w = csr_we_wb_o:
  - csr_w to CSR_MINSTRET_ADDR: cnt[31:0] <= csr_wdata; cnt[63:32] held; no increment.
  - csr_w to CSR_MINSTRETH_ADDR: cnt[63:32] <= csr_wdata; cnt[31:0] held; no increment.
  - Otherwise, retire_o: cnt <= cnt + 1, full 64-bit with carry from low to high word. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - CSR write beats increment in the same cycle; the writing instruction is not counted.
- Reset mid-stall: retired flag and counter both go to 0; no pending retire survives.
- Flush and stall asserted together: the flush wins.

Decomposition:
- Shared package (pipeline_pkg):
  - wb_meta_t, wb_control_t, wb_data_t, wb_bundle_t typedefs.
  - CSR address constants for minstret/minstreth.
  - RESULT_* encodings stay in control_macros.sv.
- Sub-module instret_counter:
  - Ports: clk_i, reset_i, inc_i, wr_lo_i, wr_hi_i, wdata_i[31:0], count_o[63:0].
- WB register reuses the existing flop module with enable ~stall_wb_i | flush_wb_i, and D muxed to 0 on flush.

Test Plan:
- Load with result_src=RESULT_MEM, reduced_data=32'hDEAD_BEEF, rd=5, reg_write=1, valid=1 -> next cycle: result_wb_o=DEADBEEF, reg_write_wb_o=1, retire_o=1, instret_o=1.
- Same instruction with rd=0 -> reg_write_wb_o=0, retire_o still 1.
- Valid instruction, then stall_wb_i held 4 cycles -> retire_o high only the first cycle, instret_o advances by exactly 1, reg_write_wb_o stays 1.
- CSR write: csr_we=1, addr=12'hB02, csr_result=32'hFFFF_FFFF, then 2 plain retires -> instret_o goes 64'h0000_0000_FFFF_FFFF, then 64'h1_0000_0000, then 64'h1_0000_0001.
- Flush and stall together on a valid instruction -> valid_wb_o=0, reg_write_wb_o=0, retire_o=0, counter unchanged.
- Counter preset to 64'hFFFF_FFFF_FFFF_FFFF (write hi, then lo), then one retire -> instret_o=0.
- reset_i during a stall -> all outputs 0, instret_o=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared typedefs and CSR address constants for the
//                writeback stage and its WB pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam logic [11:0] c_csr_minstret_addr  = 12'hB02;
    localparam logic [11:0] c_csr_minstreth_addr = 12'hB82;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        valid;
    } wb_meta_t;

    typedef struct packed {
        logic        reg_write;
        logic        csr_we;
        logic [2:0]  result_src;
        logic [11:0] csr_addr;
    } wb_control_t;

    typedef struct packed {
        logic [31:0] reduced_data;
        logic [31:0] alu_result;
        logic [31:0] pc_target;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [31:0] csr_data;
        logic [31:0] csr_result;
    } wb_data_t;

    typedef struct packed {
        wb_meta_t    meta;
        wb_control_t ctrl;
        wb_data_t    data;
    } wb_bundle_t;

endpackage

`default_nettype wire

// File: rtl/control_macros.sv
// ============================================================================
//  Module      : control_macros (macro definitions, no module)
//  Description : Result-select encodings shared by the decode and
//                writeback stages.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CONTROL_MACROS_SV
`define CONTROL_MACROS_SV

`define RESULT_ALU      3'd0
`define RESULT_MEM      3'd1
`define RESULT_PCTARGET 3'd2
`define RESULT_PCPLUS4  3'd3
`define RESULT_IMM_EXT  3'd4
`define RESULT_CSR      3'd5

`endif

`default_nettype wire

// File: rtl/flop.sv
// ============================================================================
//  Module      : flop
//  Description : Generic enabled register with synchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flop #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_q;

    // Register: clear on reset, capture D when enabled, otherwise hold.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

`default_nettype wire

// File: rtl/writeback_stage_instret_counter.sv
// ============================================================================
//  Module      : instret_counter
//  Description : 64-bit retired-instruction counter (minstret/minstreth)
//                with independent 32-bit word writes that override counting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instret_counter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] r_count;

    // Counter: a CSR write to either half suppresses the increment that cycle,
    // so the writing instruction itself is never counted.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= 64'd0;
        end else if (wr_lo_i) begin
            r_count[31:0] <= wdata_i;
        end else if (wr_hi_i) begin
            r_count[63:32] <= wdata_i;
        end else if (inc_i) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
//  Module      : writeback_stage
//  Description : Final pipeline stage. Registers memory-stage outputs, selects
//                the regfile write value, drives regfile/CSR write ports,
//                produces one retire pulse per instruction and keeps the
//                64-bit retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`include "control_macros.sv"

module writeback_stage
    import pipeline_pkg::*;
#(
    parameter logic [11:0] CSR_MINSTRET_ADDR  = c_csr_minstret_addr,
    parameter logic [11:0] CSR_MINSTRETH_ADDR = c_csr_minstreth_addr
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] instr_mem_i,
    input  logic [31:0] reduced_data_mem_i,
    input  logic [31:0] alu_result_mem_i,
    input  logic [31:0] pc_target_mem_i,
    input  logic [31:0] pc_plus4_mem_i,
    input  logic [31:0] imm_ext_mem_i,
    input  logic [31:0] csr_data_mem_i,
    input  logic [31:0] csr_result_mem_i,
    input  logic [11:0] csr_addr_mem_i,
    input  logic [4:0]  rd_mem_i,
    input  logic        valid_mem_i,
    input  logic        reg_write_mem_i,
    input  logic        csr_we_mem_i,
    input  logic [2:0]  result_src_mem_i,
    input  logic        stall_wb_i,
    input  logic        flush_wb_i,
    output logic [31:0] result_wb_o,
    output logic [4:0]  rd_wb_o,
    output logic        reg_write_wb_o,
    output logic        csr_we_wb_o,
    output logic [11:0] csr_addr_wb_o,
    output logic [31:0] csr_wdata_wb_o,
    output logic [31:0] instr_wb_o,
    output logic        valid_wb_o,
    output logic        retire_o,
    output logic [63:0] instret_o
);

    localparam int c_bundle_w = $bits(wb_bundle_t);

    wb_bundle_t  w_bundle_in;
    wb_bundle_t  w_bundle_d;
    wb_bundle_t  r_wb_q;
    logic        w_wb_en;
    logic        r_retired;
    logic        w_first;
    logic        w_csr_we;
    logic [31:0] w_result;

    // Pack the memory-stage outputs into the WB bundle.
    always_comb begin
        w_bundle_in                      = '0;
        w_bundle_in.meta.instr           = instr_mem_i;
        w_bundle_in.meta.rd              = rd_mem_i;
        w_bundle_in.meta.valid           = valid_mem_i;
        w_bundle_in.ctrl.reg_write       = reg_write_mem_i;
        w_bundle_in.ctrl.csr_we          = csr_we_mem_i;
        w_bundle_in.ctrl.result_src      = result_src_mem_i;
        w_bundle_in.ctrl.csr_addr        = csr_addr_mem_i;
        w_bundle_in.data.reduced_data    = reduced_data_mem_i;
        w_bundle_in.data.alu_result      = alu_result_mem_i;
        w_bundle_in.data.pc_target       = pc_target_mem_i;
        w_bundle_in.data.pc_plus4        = pc_plus4_mem_i;
        w_bundle_in.data.imm_ext         = imm_ext_mem_i;
        w_bundle_in.data.csr_data        = csr_data_mem_i;
        w_bundle_in.data.csr_result      = csr_result_mem_i;
    end

    // Flush overrides stall: it forces the enable and zeroes the D input.
    assign w_wb_en    = ~stall_wb_i | flush_wb_i;
    assign w_bundle_d = flush_wb_i ? wb_bundle_t'('0) : w_bundle_in;

    flop #(
        .WIDTH (c_bundle_w)
    ) u_wb_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_wb_en),
        .d_i     (w_bundle_d),
        .q_o     (r_wb_q)
    );

    // Retired flag: remembers that the held instruction already pulsed retire,
    // so a stall does not retire it again. Any register update clears it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_retired <= 1'b0;
        end else if (w_wb_en) begin
            r_retired <= 1'b0;
        end else if (w_first) begin
            r_retired <= 1'b1;
        end
    end

    assign w_first  = r_wb_q.meta.valid & ~r_retired;
    assign w_csr_we = r_wb_q.ctrl.csr_we & w_first;

    // Result mux: select the regfile write value from the registered fields.
    always_comb begin
        w_result = 32'h0;
        case (r_wb_q.ctrl.result_src)
            `RESULT_ALU:      w_result = r_wb_q.data.alu_result;
            `RESULT_MEM:      w_result = r_wb_q.data.reduced_data;
            `RESULT_PCTARGET: w_result = r_wb_q.data.pc_target;
            `RESULT_PCPLUS4:  w_result = r_wb_q.data.pc_plus4;
            `RESULT_IMM_EXT:  w_result = r_wb_q.data.imm_ext;
            `RESULT_CSR:      w_result = r_wb_q.data.csr_data;
            default:          w_result = 32'h0;
        endcase
    end

    instret_counter u_instret (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (w_first),
        .wr_lo_i (w_csr_we && (r_wb_q.ctrl.csr_addr == CSR_MINSTRET_ADDR)),
        .wr_hi_i (w_csr_we && (r_wb_q.ctrl.csr_addr == CSR_MINSTRETH_ADDR)),
        .wdata_i (r_wb_q.data.csr_result),
        .count_o (instret_o)
    );

    assign result_wb_o    = w_result;
    assign rd_wb_o        = r_wb_q.meta.rd;
    assign reg_write_wb_o = r_wb_q.ctrl.reg_write & r_wb_q.meta.valid
                            & (r_wb_q.meta.rd != 5'd0);
    assign csr_we_wb_o    = w_csr_we;
    assign csr_addr_wb_o  = r_wb_q.ctrl.csr_addr;
    assign csr_wdata_wb_o = r_wb_q.data.csr_result;
    assign instr_wb_o     = r_wb_q.meta.instr;
    assign valid_wb_o     = r_wb_q.meta.valid;
    assign retire_o       = w_first;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Self-checking bench for writeback_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

    localparam logic [2:0] c_alu = 3'd0, c_mem = 3'd1, c_pct = 3'd2,
                           c_pc4 = 3'd3, c_imm = 3'd4, c_csr = 3'd5;

    localparam logic [31:0] c_v_alu = 32'h1111_0001;
    localparam logic [31:0] c_v_mem = 32'hDEAD_BEEF;
    localparam logic [31:0] c_v_pct = 32'h0000_2000;
    localparam logic [31:0] c_v_pc4 = 32'h0000_1004;
    localparam logic [31:0] c_v_imm = 32'hFFFF_F800;
    localparam logic [31:0] c_v_csr = 32'h0000_00C5;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] instr_mem_i, reduced_data_mem_i, alu_result_mem_i;
    logic [31:0] pc_target_mem_i, pc_plus4_mem_i, imm_ext_mem_i;
    logic [31:0] csr_data_mem_i, csr_result_mem_i;
    logic [11:0] csr_addr_mem_i;
    logic [4:0]  rd_mem_i;
    logic        valid_mem_i, reg_write_mem_i, csr_we_mem_i;
    logic [2:0]  result_src_mem_i;
    logic        stall_wb_i, flush_wb_i;
    logic [31:0] result_wb_o;
    logic [4:0]  rd_wb_o;
    logic        reg_write_wb_o, csr_we_wb_o;
    logic [11:0] csr_addr_wb_o;
    logic [31:0] csr_wdata_wb_o, instr_wb_o;
    logic        valid_wb_o, retire_o;
    logic [63:0] instret_o;

    writeback_stage dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .instr_mem_i        (instr_mem_i),
        .reduced_data_mem_i (reduced_data_mem_i),
        .alu_result_mem_i   (alu_result_mem_i),
        .pc_target_mem_i    (pc_target_mem_i),
        .pc_plus4_mem_i     (pc_plus4_mem_i),
        .imm_ext_mem_i      (imm_ext_mem_i),
        .csr_data_mem_i     (csr_data_mem_i),
        .csr_result_mem_i   (csr_result_mem_i),
        .csr_addr_mem_i     (csr_addr_mem_i),
        .rd_mem_i           (rd_mem_i),
        .valid_mem_i        (valid_mem_i),
        .reg_write_mem_i    (reg_write_mem_i),
        .csr_we_mem_i       (csr_we_mem_i),
        .result_src_mem_i   (result_src_mem_i),
        .stall_wb_i         (stall_wb_i),
        .flush_wb_i         (flush_wb_i),
        .result_wb_o        (result_wb_o),
        .rd_wb_o            (rd_wb_o),
        .reg_write_wb_o     (reg_write_wb_o),
        .csr_we_wb_o        (csr_we_wb_o),
        .csr_addr_wb_o      (csr_addr_wb_o),
        .csr_wdata_wb_o     (csr_wdata_wb_o),
        .instr_wb_o         (instr_wb_o),
        .valid_wb_o         (valid_wb_o),
        .retire_o           (retire_o),
        .instret_o          (instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [4:0]  rd;
        logic        rw;
        logic        valid;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_result;
        logic [31:0] exp_result;
        logic        exp_rw;
        logic        exp_retire;
        logic        exp_csr_we;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        rw;
        logic        retire;
        logic        valid;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
    } exp_t;

    vec_t        vecs[17];
    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] m_cnt;
    logic [63:0] base;

    function automatic vec_t mk(logic [2:0] src, logic [4:0] rd, logic rw, logic valid,
                                logic csr_we, logic [11:0] addr, logic [31:0] cres,
                                logic [31:0] res, logic erw, logic eret, logic ecsr);
        vec_t v;
        v.src = src; v.rd = rd; v.rw = rw; v.valid = valid; v.csr_we = csr_we;
        v.csr_addr = addr; v.csr_result = cres; v.exp_result = res;
        v.exp_rw = erw; v.exp_retire = eret; v.exp_csr_we = ecsr;
        return v;
    endfunction

    // Reference counter: write to a half beats increment; others count retires.
    function automatic logic [63:0] next_cnt(logic [63:0] c, exp_t x);
        logic [63:0] n;
        n = c;
        if (x.csr_we && x.csr_addr == 12'hB02)      n[31:0]  = x.csr_wdata;
        else if (x.csr_we && x.csr_addr == 12'hB82) n[63:32] = x.csr_wdata;
        else if (x.retire)                          n = c + 64'd1;
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] src, input logic [4:0] rd, input logic rw,
                         input logic valid, input logic csr_we, input logic [11:0] addr,
                         input logic [31:0] cres, input logic [31:0] instr);
        result_src_mem_i = src; rd_mem_i = rd; reg_write_mem_i = rw;
        valid_mem_i = valid; csr_we_mem_i = csr_we; csr_addr_mem_i = addr;
        csr_result_mem_i = cres; instr_mem_i = instr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"},  {32'h0, result_wb_o}, 64'h0);
        check({tag, "_rd"},      {59'h0, rd_wb_o}, 64'h0);
        check({tag, "_rw"},      {63'h0, reg_write_wb_o}, 64'h0);
        check({tag, "_csr_we"},  {63'h0, csr_we_wb_o}, 64'h0);
        check({tag, "_csraddr"}, {52'h0, csr_addr_wb_o}, 64'h0);
        check({tag, "_csrwd"},   {32'h0, csr_wdata_wb_o}, 64'h0);
        check({tag, "_instr"},   {32'h0, instr_wb_o}, 64'h0);
        check({tag, "_valid"},   {63'h0, valid_wb_o}, 64'h0);
        check({tag, "_retire"},  {63'h0, retire_o}, 64'h0);
        check({tag, "_instret"}, instret_o, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(c_mem, 5'd5,  1, 1, 0, 12'h000, 32'h0,        c_v_mem, 1, 1, 0);
        vecs[1]  = mk(c_mem, 5'd0,  1, 1, 0, 12'h000, 32'h0,        c_v_mem, 0, 1, 0);
        vecs[2]  = mk(c_alu, 5'd1,  1, 1, 0, 12'h000, 32'h0,        c_v_alu, 1, 1, 0);
        vecs[3]  = mk(c_pct, 5'd2,  1, 1, 0, 12'h000, 32'h0,        c_v_pct, 1, 1, 0);
        vecs[4]  = mk(c_pc4, 5'd31, 1, 1, 0, 12'h000, 32'h0,        c_v_pc4, 1, 1, 0);
        vecs[5]  = mk(c_imm, 5'd3,  1, 1, 0, 12'h000, 32'h0,        c_v_imm, 1, 1, 0);
        vecs[6]  = mk(c_csr, 5'd4,  1, 1, 1, 12'hB02, 32'hFFFF_FFFF, c_v_csr, 1, 1, 1);
        vecs[7]  = mk(3'd6,  5'd6,  1, 1, 0, 12'h000, 32'h0,        32'h0,   1, 1, 0);
        vecs[8]  = mk(3'd7,  5'd7,  1, 1, 0, 12'h000, 32'h0,        32'h0,   1, 1, 0);
        vecs[9]  = mk(c_alu, 5'd7,  1, 0, 0, 12'h000, 32'h0,        c_v_alu, 0, 0, 0);
        vecs[10] = mk(c_csr, 5'd8,  1, 0, 1, 12'hB02, 32'h1234_5678, c_v_csr, 0, 0, 0);
        vecs[11] = mk(c_csr, 5'd9,  1, 1, 1, 12'h300, 32'hAAAA_5555, c_v_csr, 1, 1, 1);
        vecs[12] = mk(c_alu, 5'd8,  0, 1, 0, 12'h000, 32'h0,        c_v_alu, 0, 1, 0);
        vecs[13] = mk(c_csr, 5'd10, 1, 1, 1, 12'hB82, 32'hFFFF_FFFF, c_v_csr, 1, 1, 1);
        vecs[14] = mk(c_csr, 5'd11, 1, 1, 1, 12'hB02, 32'hFFFF_FFFF, c_v_csr, 1, 1, 1);
        vecs[15] = mk(c_alu, 5'd12, 1, 1, 0, 12'h000, 32'h0,        c_v_alu, 1, 1, 0);
        vecs[16] = mk(c_alu, 5'd13, 1, 0, 0, 12'h000, 32'h0,        c_v_alu, 0, 0, 0);

        reset_i = 1'b1; stall_wb_i = 1'b0; flush_wb_i = 1'b0;
        reduced_data_mem_i = c_v_mem; alu_result_mem_i = c_v_alu;
        pc_target_mem_i = c_v_pct; pc_plus4_mem_i = c_v_pc4;
        imm_ext_mem_i = c_v_imm; csr_data_mem_i = c_v_csr;
        drive(c_mem, 5'd5, 1, 1, 1, 12'hB02, 32'h5, 32'h13);
        tick(); tick();
        check_all_zero("reset");
        reset_i = 1'b0;
        m_cnt = 64'd0;

        // Table-driven vectors, back-to-back with no stalls.
        for (int i = 0; i < 17; i++) begin
            exp_t x;
            logic [31:0] instr_v;
            instr_v = 32'h0000_0013 + (32'(i) << 12);
            drive(vecs[i].src, vecs[i].rd, vecs[i].rw, vecs[i].valid, vecs[i].csr_we,
                  vecs[i].csr_addr, vecs[i].csr_result, instr_v);
            x.instr = instr_v; x.rd = vecs[i].rd; x.result = vecs[i].exp_result;
            x.rw = vecs[i].exp_rw; x.retire = vecs[i].exp_retire; x.valid = vecs[i].valid;
            x.csr_we = vecs[i].exp_csr_we; x.csr_addr = vecs[i].csr_addr;
            x.csr_wdata = vecs[i].csr_result;
            sb.push_back(x);
            tick();
            e = sb.pop_front();
            check($sformatf("v%0d_result", i), {32'h0, result_wb_o}, {32'h0, e.result});
            check($sformatf("v%0d_rd", i), {59'h0, rd_wb_o}, {59'h0, e.rd});
            check($sformatf("v%0d_instr", i), {32'h0, instr_wb_o}, {32'h0, e.instr});
            check($sformatf("v%0d_rw", i), {63'h0, reg_write_wb_o}, {63'h0, e.rw});
            check($sformatf("v%0d_retire", i), {63'h0, retire_o}, {63'h0, e.retire});
            check($sformatf("v%0d_valid", i), {63'h0, valid_wb_o}, {63'h0, e.valid});
            check($sformatf("v%0d_csr_we", i), {63'h0, csr_we_wb_o}, {63'h0, e.csr_we});
            check($sformatf("v%0d_csraddr", i), {52'h0, csr_addr_wb_o}, {52'h0, e.csr_addr});
            check($sformatf("v%0d_csrwd", i), {32'h0, csr_wdata_wb_o}, {32'h0, e.csr_wdata});
            check($sformatf("v%0d_instret", i), instret_o, m_cnt);
            if (i == 7) check("csr_lo_write", instret_o, 64'h0000_0000_FFFF_FFFF);
            if (i == 8) check("carry_to_hi", instret_o, 64'h0000_0001_0000_0000);
            if (i == 9) check("after_carry", instret_o, 64'h0000_0001_0000_0001);
            if (i == 16) check("wrap_to_zero", instret_o, 64'h0);
            m_cnt = next_cnt(m_cnt, e);
        end

        // Stall held four cycles on a valid instruction.
        drive(c_mem, 5'd5, 1, 1, 0, 12'h000, 32'h0, 32'h0000_0A13);
        tick();
        check("stall_first_retire", {63'h0, retire_o}, 64'h1);
        base = instret_o;
        stall_wb_i = 1'b1;
        drive(c_alu, 5'd9, 1, 1, 0, 12'h000, 32'h0, 32'h0000_0B13);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stall%0d_retire", k), {63'h0, retire_o}, 64'h0);
            check($sformatf("stall%0d_rw", k), {63'h0, reg_write_wb_o}, 64'h1);
            check($sformatf("stall%0d_result", k), {32'h0, result_wb_o}, {32'h0, c_v_mem});
            check($sformatf("stall%0d_instret", k), instret_o, base + 64'd1);
        end
        stall_wb_i = 1'b0;
        drive(c_alu, 5'd0, 0, 0, 0, 12'h000, 32'h0, 32'h0);
        tick();
        check("unstall_valid", {63'h0, valid_wb_o}, 64'h0);
        check("unstall_instret", instret_o, base + 64'd1);

        // Flush and stall together: flush wins.
        drive(c_alu, 5'd3, 1, 1, 0, 12'h000, 32'h0, 32'h0000_0C13);
        tick();
        check("pre_flush_retire", {63'h0, retire_o}, 64'h1);
        base = instret_o;
        stall_wb_i = 1'b1; flush_wb_i = 1'b1;
        drive(c_mem, 5'd4, 1, 1, 1, 12'hB02, 32'h0, 32'h0000_0D13);
        tick();
        check("flush_valid", {63'h0, valid_wb_o}, 64'h0);
        check("flush_rw", {63'h0, reg_write_wb_o}, 64'h0);
        check("flush_retire", {63'h0, retire_o}, 64'h0);
        check("flush_csr_we", {63'h0, csr_we_wb_o}, 64'h0);
        check("flush_instret", instret_o, base + 64'd1);
        stall_wb_i = 1'b0; flush_wb_i = 1'b0;
        drive(c_alu, 5'd0, 0, 0, 0, 12'h000, 32'h0, 32'h0);
        tick();
        check("post_flush_instret", instret_o, base + 64'd1);

        // Reset during a stall.
        drive(c_mem, 5'd6, 1, 1, 1, 12'h300, 32'h77, 32'h0000_0E13);
        tick();
        stall_wb_i = 1'b1;
        tick();
        reset_i = 1'b1;
        tick();
        check_all_zero("stall_reset");
        reset_i = 1'b0; stall_wb_i = 1'b0;
        drive(c_alu, 5'd0, 0, 0, 0, 12'h000, 32'h0, 32'h0);
        tick();
        check("post_reset_retire", {63'h0, retire_o}, 64'h0);
        check("post_reset_instret", instret_o, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
